// File: rtl/adc_cond_pkg.sv
// Shared definitions for the ADC conditioning block: FSM states, code
// width, default tuning values and a small magnitude helper.
package adc_cond_pkg;

    localparam int ADC_W          = 12;
    localparam int DIFF_W         = 13;
    localparam int CAL_SHIFT_DEF  = 8;
    localparam int AVG_SHIFT_DEF  = 3;
    localparam int TRIP_LEVEL_DEF = 1800;

    typedef enum logic {
        ST_CAL = 1'b0,
        ST_RUN = 1'b1
    } cond_state_e;

    // Magnitude of an offset-corrected difference; the range is -4095..+4095
    // so the negation never overflows 13 bits.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic signed [DIFF_W-1:0] v);
        logic signed [DIFF_W-1:0] neg;
        neg = -v;
        return v[DIFF_W-1] ? neg : v;
    endfunction

endpackage

// File: rtl/adc_conditioner_if.sv
// Sample/control bundle between the ADC front end and the conditioner.
interface adc_conditioner_if;
    import adc_cond_pkg::*;

    logic [15:0]      adc_value;
    logic             adc_valid;
    logic             recal;
    logic             trip_clear;
    logic [15:0]      sample_out;
    logic             sample_valid;
    logic [ADC_W-1:0] offset;
    logic             cal_done;
    logic             trip;

    modport master (
        output adc_value, adc_valid, recal, trip_clear,
        input  sample_out, sample_valid, offset, cal_done, trip
    );

    modport slave (
        input  adc_value, adc_valid, recal, trip_clear,
        output sample_out, sample_valid, offset, cal_done, trip
    );

endinterface

// File: rtl/adc_conditioner_avg_ring.sv
// Moving-average history: DEPTH entries with a single pointer that marks
// both the oldest entry (read) and the slot the next sample overwrites.
module avg_ring #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];

    assign rd_data = mem_r[ptr_r];

    // Pointer: cleared on window restart, advances once per written sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (clr) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (wr_en) begin
            ptr_r <= (ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr_r + PTR_W'(1);
        end
    end

    // Storage: zeroed on window restart so the average ramps from zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/adc_conditioner.sv
// ADC conditioner: averages 2^CAL_SHIFT samples to find the zero offset,
// then streams offset-corrected, moving-averaged samples with a latched
// overcurrent trip. Two register stages from adc_valid to sample_valid.
module adc_conditioner
    import adc_cond_pkg::*;
#(
    parameter int CAL_SHIFT  = CAL_SHIFT_DEF,
    parameter int AVG_SHIFT  = AVG_SHIFT_DEF,
    parameter int TRIP_LEVEL = TRIP_LEVEL_DEF
) (
    input  logic              clk_80_mhz,
    input  logic              rst_n,
    adc_conditioner_if.slave  bus
);
    localparam int ACC_W = ADC_W + CAL_SHIFT;
    localparam int SUM_W = DIFF_W + AVG_SHIFT;
    localparam int DEPTH = 1 << AVG_SHIFT;
    localparam logic [DIFF_W-1:0] TRIP_LIM = DIFF_W'(TRIP_LEVEL);

    cond_state_e              state_r;
    logic [ACC_W-1:0]         acc_r;
    logic [CAL_SHIFT-1:0]     cnt_r;
    logic [ADC_W-1:0]         offset_r;
    logic                     cal_done_r;

    logic                     v1_r;
    logic signed [DIFF_W-1:0] diff_r;
    logic                     over_r;

    logic signed [SUM_W-1:0]  sum_r;
    logic [15:0]              sample_out_r;
    logic                     sample_valid_r;
    logic                     trip_r;

    logic [ADC_W-1:0]         code_s;
    logic                     take_s;
    logic                     cal_last_s;
    logic                     ring_clr_s;
    logic                     wr_en_s;
    logic [ACC_W-1:0]         acc_next_s;
    logic signed [DIFF_W-1:0] diff_s;
    logic                     over_s;
    logic signed [DIFF_W-1:0] oldest_s;
    logic signed [SUM_W-1:0]  sum_next_s;
    logic signed [SUM_W-1:0]  avg_s;
    logic                     unused_bits_s;

    // Datapath and control decodes for the current cycle.
    always_comb begin
        code_s        = bus.adc_value[ADC_W-1:0];
        unused_bits_s = ^bus.adc_value[15:ADC_W];
        take_s        = bus.adc_valid & ~bus.recal;
        cal_last_s    = (state_r == ST_CAL) & take_s & (cnt_r == {CAL_SHIFT{1'b1}});
        ring_clr_s    = bus.recal | cal_last_s;
        wr_en_s       = v1_r & ~bus.recal;
        acc_next_s    = acc_r + ACC_W'(code_s);
        diff_s        = $signed({1'b0, code_s}) - $signed({1'b0, offset_r});
        over_s        = abs_diff(diff_s) > TRIP_LIM;
        sum_next_s    = sum_r + SUM_W'(diff_r) - SUM_W'(oldest_s);
        avg_s         = sum_next_s >>> AVG_SHIFT;
    end

    // Calibration FSM: accumulate in CAL, load the offset on the last sample.
    always_ff @(posedge clk_80_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_CAL;
            acc_r      <= {ACC_W{1'b0}};
            cnt_r      <= {CAL_SHIFT{1'b0}};
            offset_r   <= {ADC_W{1'b0}};
            cal_done_r <= 1'b0;
        end else if (bus.recal) begin
            state_r    <= ST_CAL;
            acc_r      <= {ACC_W{1'b0}};
            cnt_r      <= {CAL_SHIFT{1'b0}};
            cal_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CAL: begin
                    if (cal_last_s) begin
                        offset_r   <= acc_next_s[ACC_W-1:CAL_SHIFT];
                        acc_r      <= {ACC_W{1'b0}};
                        cnt_r      <= {CAL_SHIFT{1'b0}};
                        state_r    <= ST_RUN;
                        cal_done_r <= 1'b1;
                    end else if (bus.adc_valid) begin
                        acc_r <= acc_next_s;
                        cnt_r <= cnt_r + CAL_SHIFT'(1);
                    end
                end
                ST_RUN: begin
                    cal_done_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_CAL;
                    cal_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: offset correction and trip-threshold compare of RUN samples.
    always_ff @(posedge clk_80_mhz or negedge rst_n) begin
        if (!rst_n) begin
            v1_r   <= 1'b0;
            diff_r <= {DIFF_W{1'b0}};
            over_r <= 1'b0;
        end else begin
            v1_r   <= (state_r == ST_RUN) & take_s;
            diff_r <= diff_s;
            over_r <= over_s;
        end
    end

    avg_ring #(
        .DEPTH (DEPTH),
        .WIDTH (DIFF_W)
    ) u_ring (
        .clk     (clk_80_mhz),
        .rst_n   (rst_n),
        .clr     (ring_clr_s),
        .wr_en   (wr_en_s),
        .wr_data (diff_r),
        .rd_data (oldest_s)
    );

    // Stage 2: running sum, averaged output and trip latch; recal drops
    // whatever sits in stage 1.
    always_ff @(posedge clk_80_mhz or negedge rst_n) begin
        if (!rst_n) begin
            sum_r          <= {SUM_W{1'b0}};
            sample_out_r   <= 16'd0;
            sample_valid_r <= 1'b0;
            trip_r         <= 1'b0;
        end else begin
            sample_valid_r <= wr_en_s;
            if (ring_clr_s) begin
                sum_r <= {SUM_W{1'b0}};
            end else if (wr_en_s) begin
                sum_r <= sum_next_s;
            end
            if (wr_en_s) begin
                sample_out_r <= 16'(avg_s);
            end
            if (wr_en_s & over_r) begin
                trip_r <= 1'b1;
            end else if (bus.trip_clear) begin
                trip_r <= 1'b0;
            end
        end
    end

    assign bus.sample_out   = sample_out_r;
    assign bus.sample_valid = sample_valid_r;
    assign bus.offset       = offset_r;
    assign bus.cal_done     = cal_done_r;
    assign bus.trip         = trip_r;

endmodule

// File: tb/tb_adc_conditioner.sv
// Directed bench for adc_conditioner: stimulus pushes expected outputs
// into a queue, a negedge monitor pops and compares on sample_valid.
module tb_adc_conditioner;
    import adc_cond_pkg::*;

    typedef struct {
        int sample;
        int trip;
        int due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t q[$];
    exp_t mon_e;

    int exp_ramp[8] = '{12, 25, 37, 50, 62, 75, 87, 100};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    adc_conditioner_if bus_if ();

    adc_conditioner #(
        .CAL_SHIFT  (8),
        .AVG_SHIFT  (3),
        .TRIP_LEVEL (1800)
    ) dut (
        .clk_80_mhz (clk),
        .rst_n      (rst_n),
        .bus        (bus_if)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic send(input logic [15:0] val, input bit has_exp, input int s, input int t);
        @(negedge clk);
        bus_if.adc_value  = val;
        bus_if.adc_valid  = 1'b1;
        bus_if.recal      = 1'b0;
        bus_if.trip_clear = 1'b0;
        if (has_exp) q.push_back('{s, t, cyc + 2});
    endtask

    task automatic send_n(input logic [15:0] val, input int n);
        repeat (n) send(val, 1'b0, 0, 0);
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_if.adc_valid  = 1'b0;
            bus_if.recal      = 1'b0;
            bus_if.trip_clear = 1'b0;
        end
    endtask

    task automatic pulse_recal();
        @(negedge clk);
        bus_if.adc_valid = 1'b0;
        bus_if.recal     = 1'b1;
        quiet(1);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus_if.adc_valid  = 1'b0;
        bus_if.trip_clear = 1'b1;
        quiet(1);
    endtask

    // Monitor: every sample_valid must match the oldest pending expectation.
    always @(negedge clk) begin
        if (bus_if.sample_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_sample_valid: got sample_out=%0d at cycle %0d, required no pulse",
                         $signed(bus_if.sample_out), cyc);
            end else begin
                mon_e = q.pop_front();
                chk("sample_out", int'($signed(bus_if.sample_out)), mon_e.sample);
                chk("trip_at_valid", int'(bus_if.trip), mon_e.trip);
                chk("valid_latency_cycle", cyc, mon_e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        bus_if.adc_value  = 16'd0;
        bus_if.adc_valid  = 1'b0;
        bus_if.recal      = 1'b0;
        bus_if.trip_clear = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_sample_out", int'(bus_if.sample_out), 0);
        chk("rst_sample_valid", int'(bus_if.sample_valid), 0);
        chk("rst_offset", int'(bus_if.offset), 0);
        chk("rst_cal_done", int'(bus_if.cal_done), 0);
        chk("rst_trip", int'(bus_if.trip), 0);
        rst_n = 1'b1;

        // Calibration at 2048, then spaced ramp (upper bits set on odd samples)
        send_n(16'd2048, 255);
        quiet(1);
        chk("cal_done_after_255", int'(bus_if.cal_done), 0);
        send(16'd2048, 1'b0, 0, 0);
        quiet(1);
        chk("offset_2048", int'(bus_if.offset), 2048);
        chk("cal_done_after_256", int'(bus_if.cal_done), 1);
        for (int i = 0; i < 8; i++) begin
            send((i % 2 == 1) ? 16'hF864 : 16'd2148, 1'b1, exp_ramp[i], 0);
            quiet(1);
        end
        quiet(3);
        chk("queue_drained_ramp", q.size(), 0);

        // Fresh window: large negative sample, trips, then clears
        pulse_recal();
        chk("recal_cal_done_low", int'(bus_if.cal_done), 0);
        chk("recal_offset_kept", int'(bus_if.offset), 2048);
        send_n(16'd2048, 256);
        quiet(1);
        chk("recal_cal_done_high", int'(bus_if.cal_done), 1);
        send(16'd0, 1'b1, -256, 1);
        quiet(3);
        chk("trip_held_2048", int'(bus_if.trip), 1);
        pulse_clear();
        chk("trip_cleared_1", int'(bus_if.trip), 0);

        // Threshold boundary: 1801 trips, 1800 does not
        send(16'd3849, 1'b1, -31, 1);
        quiet(3);
        chk("trip_held_1801", int'(bus_if.trip), 1);
        pulse_clear();
        chk("trip_cleared_2", int'(bus_if.trip), 0);
        send(16'd3848, 1'b1, 194, 0);
        quiet(3);
        chk("no_trip_1800", int'(bus_if.trip), 0);

        // Set beats a coincident clear
        send(16'd0, 1'b1, -62, 1);
        @(negedge clk);
        bus_if.adc_valid  = 1'b0;
        bus_if.trip_clear = 1'b1;
        quiet(1);
        chk("trip_set_wins", int'(bus_if.trip), 1);
        quiet(2);

        // Back-to-back samples after a fresh calibration (trip still latched)
        pulse_recal();
        send_n(16'd2048, 256);
        quiet(1);
        for (int i = 0; i < 8; i++) send(16'd2148, 1'b1, exp_ramp[i], 1);
        quiet(3);
        chk("queue_drained_b2b", q.size(), 0);

        // recal one cycle after an accepted sample discards it
        send(16'd2148, 1'b0, 0, 0);
        @(negedge clk);
        bus_if.adc_valid = 1'b0;
        bus_if.recal     = 1'b1;
        quiet(1);
        chk("inflight_cal_done_low", int'(bus_if.cal_done), 0);
        chk("inflight_offset_kept", int'(bus_if.offset), 2048);
        chk("inflight_trip_kept", int'(bus_if.trip), 1);
        quiet(3);

        // recal with coincident adc_valid: that sample must be ignored
        @(negedge clk);
        bus_if.adc_value = 16'd4000;
        bus_if.adc_valid = 1'b1;
        bus_if.recal     = 1'b1;
        send_n(16'd1000, 255);
        quiet(1);
        chk("cal1000_done_after_255", int'(bus_if.cal_done), 0);
        send(16'd1000, 1'b0, 0, 0);
        quiet(1);
        chk("offset_1000", int'(bus_if.offset), 1000);
        chk("cal1000_done", int'(bus_if.cal_done), 1);

        // Asynchronous reset mid-calibration
        pulse_recal();
        send_n(16'd500, 100);
        @(negedge clk);
        bus_if.adc_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sample_out", int'(bus_if.sample_out), 0);
        chk("arst_sample_valid", int'(bus_if.sample_valid), 0);
        chk("arst_offset", int'(bus_if.offset), 0);
        chk("arst_cal_done", int'(bus_if.cal_done), 0);
        chk("arst_trip", int'(bus_if.trip), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_n(16'd3000, 255);
        quiet(1);
        chk("postrst_cal_done_255", int'(bus_if.cal_done), 0);
        send(16'd3000, 1'b0, 0, 0);
        quiet(1);
        chk("postrst_offset_3000", int'(bus_if.offset), 3000);
        chk("postrst_cal_done", int'(bus_if.cal_done), 1);
        quiet(3);
        chk("queue_drained_end", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
